// File: rtl/alu4_pkg.sv
// Shared encodings for the 4-bit ALU sequencing stage: command kinds, FSM states
// and flag-register bit positions ({Z,V,R,C} from bit 3 down to bit 0).
package alu4_pkg;

  localparam logic [1:0] KIND_ALU   = 2'b00;
  localparam logic [1:0] KIND_LOADI = 2'b01;
  localparam logic [1:0] KIND_READ  = 2'b10;
  localparam logic [1:0] KIND_SETF  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_R = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 3;

endpackage

// File: rtl/alu4_regfile.sv
// 4 x 4-bit register file: two combinational read ports, one synchronous write port.
// Reads see the state after any write on the previous edge; no internal bypass.
module alu4_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ra_addr,
  input  logic [1:0] rb_addr,
  output logic [3:0] ra_data,
  output logic [3:0] rb_data,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data
);

  logic [3:0] regs [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

endmodule

// File: rtl/alu4_exec_ctrl.sv
// Sequencer in front of the combinational 4-bit ALU: accept -> 1-cycle EXEC -> RESP.
// Response held until rsp_ready; a new command may be taken on the same edge (2-cycle spacing).
module alu4_exec_ctrl
  import alu4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_kind,
  input  logic [3:0] cmd_op,
  input  logic [1:0] cmd_rd,
  input  logic [1:0] cmd_ra,
  input  logic [1:0] cmd_rb,
  input  logic       cmd_wb,
  input  logic [3:0] cmd_imm,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_op,
  output logic       alu_cin,
  output logic       alu_rin,
  input  logic [3:0] alu_res,
  input  logic       alu_cout,
  input  logic       alu_rout,
  input  logic       alu_v,
  input  logic       alu_z,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_data,
  output logic [3:0] rsp_flags
);

  state_t     state, state_nxt;
  logic       accept, exec_done;
  logic [1:0] kind_q, rd_q;
  logic       wb_q;
  logic [3:0] imm_q, result_q, flags_q, flags_alu;
  logic [3:0] rf_a, rf_b, rf_wdata;
  logic       rf_we;

  alu4_regfile u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (cmd_ra),
    .rb_addr (cmd_rb),
    .ra_data (rf_a),
    .rb_data (rf_b),
    .wr_en   (rf_we),
    .wr_addr (rd_q),
    .wr_data (rf_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_EXEC;
      end
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: begin
        cmd_ready = rsp_ready;
        if (rsp_ready) state_nxt = cmd_valid ? ST_EXEC : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign accept    = cmd_valid & cmd_ready;
  assign exec_done = (state == ST_EXEC);
  assign rsp_valid = (state == ST_RESP);
  assign rsp_data  = result_q;
  assign rsp_flags = flags_q;

  always_comb begin
    flags_alu         = '0;
    flags_alu[FLAG_C] = alu_cout;
    flags_alu[FLAG_R] = alu_rout;
    flags_alu[FLAG_V] = alu_v;
    flags_alu[FLAG_Z] = alu_z;
  end

  // Writeback lands on the EXEC edge, so an operand read at the next accept already sees it.
  assign rf_we    = exec_done & (((kind_q == KIND_ALU) & wb_q) | (kind_q == KIND_LOADI));
  assign rf_wdata = (kind_q == KIND_LOADI) ? imm_q : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kind_q   <= KIND_ALU;
      rd_q     <= '0;
      wb_q     <= 1'b0;
      imm_q    <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      alu_cin  <= 1'b0;
      alu_rin  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      if (accept) begin
        kind_q  <= cmd_kind;
        rd_q    <= cmd_rd;
        wb_q    <= cmd_wb;
        imm_q   <= cmd_imm;
        alu_op  <= cmd_op;
        alu_a   <= rf_a;
        alu_b   <= rf_b;
        alu_cin <= flags_q[FLAG_C];
        alu_rin <= flags_q[FLAG_R];
      end
      if (exec_done) begin
        case (kind_q)
          KIND_ALU: begin
            result_q <= alu_res;
            flags_q  <= flags_alu;
          end
          KIND_LOADI: result_q <= imm_q;
          KIND_READ:  result_q <= alu_a;
          KIND_SETF: begin
            result_q <= imm_q;
            flags_q  <= imm_q;
          end
          default: result_q <= result_q;
        endcase
      end
    end
  end

endmodule
